schoolbook_div: RTL and testbench

- Bit-serial restoring divider; the inverse of the bit-serial shift-add schoolbook multiplier in the TalTech large-arithmetic library.
- Takes a 2W-bit dividend, such as a full multiplier product, and a W-bit divisor.
- Returns a W-bit quotient and a W-bit remainder after W iteration cycles.
- Used to check multiplier results and for modular reduction in the large-operand datapath.

---
 rtl/schoolbook_div_pkg.sv | 13 +
 rtl/schoolbook_div_step.sv | 24 ++
 rtl/schoolbook_div.sv | 142 ++++++++++++++
 tb/tb_schoolbook_div.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/schoolbook_div_pkg.sv
// schoolbook_div shared package: default widths and FSM state encoding.
// No ports; imported by schoolbook_div and schoolbook_div_step.
package schoolbook_pkg;

  localparam int W_DEF  = 521;
  localparam int CW_DEF = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/schoolbook_div_step.sv
// schoolbook_div_step: one restoring-division step, (W+1)-bit compare/subtract.
// Ports: i_t trial remainder, i_b divisor -> o_p next remainder, o_qbit quotient bit.
module schoolbook_div_step
  import schoolbook_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W:0]   i_t,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_p,
  output logic         o_qbit
);

  // When the subtract happens the result is below B, so its top bit is
  // always zero and a W-bit subtract gives the same low bits.
  always_comb begin
    o_qbit = (i_t >= {1'b0, i_b});
    o_p    = i_t[W-1:0];
    if (o_qbit) begin
      o_p = i_t[W-1:0] - i_b;
    end
  end

endmodule

// File: rtl/schoolbook_div.sv
// schoolbook_div: bit-serial restoring divider, 2W/W -> W quotient + W remainder.
// Ports: clk, rst (sync, high), start, a[2W], b[W] -> busy, done, q, r, ovf.
module schoolbook_div
  import schoolbook_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = CW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*W-1:0] a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   q,
  output logic [W-1:0]   r,
  output logic           ovf
);

  state_t        r_state;
  state_t        w_state_n;
  logic [W-1:0]  r_p;
  logic [W-1:0]  w_p_n;
  logic [W-1:0]  r_d;
  logic [W-1:0]  w_d_n;
  logic [W-1:0]  r_b;
  logic [W-1:0]  w_b_n;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_n;
  logic          r_done;
  logic          w_done_n;
  logic [W-1:0]  r_q;
  logic [W-1:0]  w_q_n;
  logic [W-1:0]  r_r;
  logic [W-1:0]  w_r_n;
  logic          r_ovf;
  logic          w_ovf_n;

  logic [W:0]    w_t;
  logic [W-1:0]  w_step_p;
  logic          w_qbit;
  logic          w_hi_ovf;
  logic          w_last;
  logic [W-1:0]  w_d_shift;

  // The remainder never exceeds B-1, so only W bits are kept;
  // the trial value regains the (W+1)-th bit through the shift.
  assign w_t = {r_p, r_d[W-1]};

  schoolbook_div_step #(
    .W (W)
  ) u_step (
    .i_t    (w_t),
    .i_b    (r_b),
    .o_p    (w_step_p),
    .o_qbit (w_qbit)
  );

  // r_d is both the dividend-bit source (MSB out) and the quotient
  // accumulator (LSB in); after W shifts it holds only quotient bits.
  assign w_d_shift = {r_d[W-2:0], w_qbit};

  assign w_hi_ovf = (a[2*W-1:W] >= b);
  assign w_last   = (r_cnt == CW'(W - 1));

  always_comb begin
    w_state_n = r_state;
    w_p_n     = r_p;
    w_d_n     = r_d;
    w_b_n     = r_b;
    w_cnt_n   = r_cnt;
    w_done_n  = 1'b0;
    w_q_n     = r_q;
    w_r_n     = r_r;
    w_ovf_n   = r_ovf;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_b_n = b;
          if (w_hi_ovf) begin
            w_q_n    = '0;
            w_r_n    = '0;
            w_ovf_n  = 1'b1;
            w_done_n = 1'b1;
          end else begin
            w_p_n     = a[2*W-1:W];
            w_d_n     = a[W-1:0];
            w_cnt_n   = '0;
            w_ovf_n   = 1'b0;
            w_state_n = RUN;
          end
        end
      end
      RUN: begin
        w_p_n   = w_step_p;
        w_d_n   = w_d_shift;
        w_cnt_n = r_cnt + CW'(1);
        if (w_last) begin
          w_q_n     = w_d_shift;
          w_r_n     = w_step_p;
          w_done_n  = 1'b1;
          w_state_n = IDLE;
        end
      end
      default: begin
        w_state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_p     <= '0;
      r_d     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_q     <= '0;
      r_r     <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_p     <= w_p_n;
      r_d     <= w_d_n;
      r_b     <= w_b_n;
      r_cnt   <= w_cnt_n;
      r_done  <= w_done_n;
      r_q     <= w_q_n;
      r_r     <= w_r_n;
      r_ovf   <= w_ovf_n;
    end
  end

  assign busy = (r_state == RUN);
  assign done = r_done;
  assign q    = r_q;
  assign r    = r_r;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_schoolbook_div.sv
// tb_schoolbook_div: vectors + random checks for W=8 and W=521 dividers.
// Reference results come from plain / and % arithmetic on wide vectors.
module tb_schoolbook_div;

  logic clk;
  logic rst;

  logic        start8;
  logic [15:0] a8;
  logic [7:0]  b8;
  logic        busy8, done8, ovf8;
  logic [7:0]  q8, r8;

  logic          startl;
  logic [1041:0] al;
  logic [520:0]  bl;
  logic          busyl, donel, ovfl;
  logic [520:0]  ql, rl;

  int n_vec = 0;
  int n_err = 0;

  schoolbook_div #(.W(8), .CW(4)) u_d8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .busy  (busy8),
    .done  (done8),
    .q     (q8),
    .r     (r8),
    .ovf   (ovf8)
  );

  schoolbook_div #(.W(521), .CW(10)) u_dl (
    .clk   (clk),
    .rst   (rst),
    .start (startl),
    .a     (al),
    .b     (bl),
    .busy  (busyl),
    .done  (donel),
    .q     (ql),
    .r     (rl),
    .ovf   (ovfl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        ovf;
  } vec8_t;

  task automatic chk(input string nm, input logic [520:0] act,
                     input logic [520:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called from the cycle in which the new start should be sampled;
  // returns in the cycle where done is observed (or after the bound).
  task automatic op8(input logic [15:0] av, input logic [7:0] bv,
                     input logic [7:0] eq, input logic [7:0] er,
                     input logic eo, input int restart_at);
    int cyc;
    int nb;
    start8 = 1'b1;
    a8 = av;
    b8 = bv;
    tick();
    start8 = 1'b0;
    a8 = 16'($urandom);
    b8 = 8'($urandom);
    cyc = 0;
    nb = 0;
    while (!done8 && cyc < 40) begin
      if (busy8) nb++;
      if (cyc == restart_at) begin
        start8 = 1'b1;
        a8 = ~av;
        b8 = bv ^ 8'h5A;
      end
      tick();
      cyc++;
      start8 = 1'b0;
      a8 = 16'($urandom);
      b8 = 8'($urandom);
    end
    chk("lat8", 521'(cyc), eo ? 521'd0 : 521'd8);
    chk("busycyc8", 521'(nb), eo ? 521'd0 : 521'd8);
    chk("done8", 521'(done8), 521'd1);
    chk("busy_at_done8", 521'(busy8), 521'd0);
    chk("q8", 521'(q8), 521'(eq));
    chk("r8", 521'(r8), 521'(er));
    chk("ovf8", 521'(ovf8), 521'(eo));
  endtask

  task automatic opl(input logic [1041:0] av, input logic [520:0] bv,
                     input logic [520:0] eq, input logic [520:0] er,
                     input logic eo);
    int cyc;
    int nb;
    startl = 1'b1;
    al = av;
    bl = bv;
    tick();
    startl = 1'b0;
    al = ~av;
    bl = ~bv;
    cyc = 0;
    nb = 0;
    while (!donel && cyc < 600) begin
      if (busyl) nb++;
      tick();
      cyc++;
    end
    chk("latL", 521'(cyc), eo ? 521'd0 : 521'd521);
    chk("busycycL", 521'(nb), eo ? 521'd0 : 521'd521);
    chk("doneL", 521'(donel), 521'd1);
    chk("qL", ql, eq);
    chk("rL", rl, er);
    chk("ovfL", 521'(ovfl), 521'(eo));
  endtask

  function automatic logic [520:0] rnd521();
    logic [543:0] t;
    for (int i = 0; i < 17; i++) t[i*32 +: 32] = $urandom;
    return t[520:0];
  endfunction

  // Reference for W=8: plain integer division with the
  // high-half overflow rule.
  task automatic rand8();
    logic [15:0] av;
    logic [7:0]  bv;
    logic [15:0] qq;
    logic [15:0] rr;
    logic        eo;
    av = 16'($urandom);
    bv = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
    if ($urandom_range(0, 3) != 0 && bv != 0)
      av[15:8] = 8'($urandom_range(0, int'(bv) - 1));
    eo = (av[15:8] >= bv);
    qq = 16'd0;
    rr = 16'd0;
    if (!eo) begin
      qq = av / {8'd0, bv};
      rr = av % {8'd0, bv};
    end
    op8(av, bv, qq[7:0], rr[7:0], eo, -1);
  endtask

  vec8_t tv[10];

  initial begin
    logic [520:0]  x;
    logic [520:0]  y;
    logic [1041:0] xx;
    logic [1041:0] yy;
    logic [1041:0] prod;
    logic [1041:0] qq;
    logic [1041:0] rr;

    tv[0] = '{16'd1000,  8'd37,  8'd27,  8'd1,   1'b0};
    tv[1] = '{16'h1234,  8'h00,  8'h00,  8'h00,  1'b1};
    tv[2] = '{16'hFF00,  8'hFF,  8'h00,  8'h00,  1'b1};
    tv[3] = '{16'hFEFF,  8'hFF,  8'hFF,  8'hFE,  1'b0};
    tv[4] = '{16'd100,   8'd7,   8'd14,  8'd2,   1'b0};
    tv[5] = '{16'h00FF,  8'h01,  8'hFF,  8'h00,  1'b0};
    tv[6] = '{16'h0100,  8'h01,  8'h00,  8'h00,  1'b1};
    tv[7] = '{16'h7FFF,  8'h80,  8'hFF,  8'h7F,  1'b0};
    tv[8] = '{16'hFFFF,  8'hFF,  8'h00,  8'h00,  1'b1};
    tv[9] = '{16'd0,     8'd3,   8'd0,   8'd0,   1'b0};

    rst = 1'b1;
    start8 = 1'b0;
    a8 = '0;
    b8 = '0;
    startl = 1'b0;
    al = '0;
    bl = '0;
    tick();
    tick();
    chk("rst_busy8", 521'(busy8), 521'd0);
    chk("rst_done8", 521'(done8), 521'd0);
    chk("rst_q8", 521'(q8), 521'd0);
    chk("rst_r8", 521'(r8), 521'd0);
    chk("rst_ovf8", 521'(ovf8), 521'd0);
    chk("rst_busyL", 521'(busyl), 521'd0);
    chk("rst_qL", ql, 521'd0);
    rst = 1'b0;
    tick();

    // Consecutive ops start in the done cycle of the previous one.
    for (int i = 0; i < 10; i++)
      op8(tv[i].a, tv[i].b, tv[i].q, tv[i].r, tv[i].ovf, -1);

    // Start re-pulsed in RUN cycle 3 is ignored.
    op8(16'd1000, 8'd37, 8'd27, 8'd1, 1'b0, 3);

    // done is a single-cycle pulse; results hold afterwards.
    tick();
    chk("done_pulse8", 521'(done8), 521'd0);
    chk("hold_q8", 521'(q8), 521'd27);
    chk("hold_r8", 521'(r8), 521'd1);

    // Reset in RUN cycle 4 wipes everything.
    start8 = 1'b1;
    a8 = 16'd4321;
    b8 = 8'd99;
    tick();
    start8 = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_busy8", 521'(busy8), 521'd0);
    chk("mrst_done8", 521'(done8), 521'd0);
    chk("mrst_q8", 521'(q8), 521'd0);
    chk("mrst_r8", 521'(r8), 521'd0);
    chk("mrst_ovf8", 521'(ovf8), 521'd0);
    repeat (9) tick();
    chk("mrst_nodone8", 521'(done8), 521'd0);
    op8(16'd4321, 8'd99, 8'd43, 8'd64, 1'b0, -1);

    for (int i = 0; i < 150; i++) rand8();

    // Wide divider: products, products plus 5, general, overflow.
    for (int i = 0; i < 2; i++) begin
      x = rnd521();
      y = rnd521();
      if (y <= 521'd5) y = 521'd6;
      xx = {521'd0, x};
      yy = {521'd0, y};
      prod = xx * yy;
      opl(prod, y, x, 521'd0, 1'b0);
      opl(prod + 1042'd5, y, x, 521'd5, 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      y = rnd521();
      y[520] = 1'b1;
      x = rnd521();
      x[520] = 1'b0;
      prod = {x, rnd521()};
      yy = {521'd0, y};
      qq = prod / yy;
      rr = prod % yy;
      opl(prod, y, qq[520:0], rr[520:0], 1'b0);
    end
    y = rnd521();
    opl({y, rnd521()}, y, 521'd0, 521'd0, 1'b1);
    opl({rnd521(), rnd521()}, 521'd0, 521'd0, 521'd0, 1'b1);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
